// File: rtl/nmea_pkg.sv
// Shared types and constants for the NMEA GLL sentence encoder.
// The NMEA_CHECKSUM_EN macro selects the 28-byte "*CC" form over the 25-byte form.
package nmea_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
    } nmea_state_e;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_N      = 8'h4E;
    localparam logic [7:0] ASCII_S      = 8'h53;
    localparam logic [7:0] ASCII_E      = 8'h45;
    localparam logic [7:0] ASCII_W      = 8'h57;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_V      = 8'h56;
    localparam logic [7:0] ASCII_G      = 8'h47;
    localparam logic [7:0] ASCII_L      = 8'h4C;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    localparam int SENTENCE_LEN_CSUM   = 28;
    localparam int SENTENCE_LEN_NOCSUM = 25;

    localparam logic [7:0] LAT_DEG_MAX = 8'd90;
    localparam logic [7:0] LON_DEG_MAX = 8'd180;
    localparam logic [7:0] MIN_MAX     = 8'd59;

    // Checksum covers the bytes strictly between '$' (index 0) and '*' (index 23).
    localparam logic [4:0] CSUM_FIRST_IDX = 5'd1;
    localparam logic [4:0] CSUM_LAST_IDX  = 5'd22;

    function automatic logic [7:0] sat8(input logic [7:0] value, input logic [7:0] limit);
        return (value > limit) ? limit : value;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/bin2dec_ascii.sv
// Combinational 8-bit binary to three zero-padded ASCII decimal digits.
module bin2dec_ascii
    import nmea_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] ascii_hundreds,
    output logic [7:0] ascii_tens,
    output logic [7:0] ascii_ones
);

    logic [7:0] rem_100;

    always_comb begin
        rem_100        = value % 8'd100;
        ascii_hundreds = ASCII_ZERO + (value / 8'd100);
        ascii_tens     = ASCII_ZERO + (rem_100 / 8'd10);
        ascii_ones     = ASCII_ZERO + (rem_100 % 8'd10);
    end

endmodule

// File: rtl/nmea_encoder.sv
// Emits one "$<TALKER>GLL,DDMM,h,DDDMM,h,S[*CC]\r\n" sentence per start request.
// Define NMEA_CHECKSUM_EN to append the running XOR checksum "*CC".
module nmea_encoder
    import nmea_pkg::*;
#(
    parameter logic [15:0] TALKER_ID = 16'h4750,
    parameter int          DATA_BITS = 8
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           lat_deg,
    input  logic [7:0]           lat_min,
    input  logic [7:0]           lon_deg,
    input  logic [7:0]           lon_min,
    input  logic                 lat_south,
    input  logic                 lon_west,
    input  logic                 valid_fix,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 busy,
    output logic                 done,
    output nmea_state_e          dbg_state
);

`ifdef NMEA_CHECKSUM_EN
    localparam logic [4:0] LAST_IDX = 5'(SENTENCE_LEN_CSUM - 1);
`else
    localparam logic [4:0] LAST_IDX = 5'(SENTENCE_LEN_NOCSUM - 1);
`endif

    nmea_state_e state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  lat_deg_q, lat_deg_d, lat_min_q, lat_min_d;
    logic [7:0]  lon_deg_q, lon_deg_d, lon_min_q, lon_min_d;
    logic        lat_south_q, lat_south_d, lon_west_q, lon_west_d;
    logic        valid_fix_q, valid_fix_d;
`ifdef NMEA_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic [7:0] lat_deg_h, lat_deg_t, lat_deg_o;
    logic [7:0] lat_min_h, lat_min_t, lat_min_o;
    logic [7:0] lon_deg_h, lon_deg_t, lon_deg_o;
    logic [7:0] lon_min_h, lon_min_t, lon_min_o;
    logic       unused_digits;
    logic [4:0] sel_idx;
    logic [7:0] next_byte;

    bin2dec_ascii u_lat_deg (.value(lat_deg_q), .ascii_hundreds(lat_deg_h),
                             .ascii_tens(lat_deg_t), .ascii_ones(lat_deg_o));
    bin2dec_ascii u_lat_min (.value(lat_min_q), .ascii_hundreds(lat_min_h),
                             .ascii_tens(lat_min_t), .ascii_ones(lat_min_o));
    bin2dec_ascii u_lon_deg (.value(lon_deg_q), .ascii_hundreds(lon_deg_h),
                             .ascii_tens(lon_deg_t), .ascii_ones(lon_deg_o));
    bin2dec_ascii u_lon_min (.value(lon_min_q), .ascii_hundreds(lon_min_h),
                             .ascii_tens(lon_min_t), .ascii_ones(lon_min_o));

    // Saturation keeps these hundreds digits at '0'; the fields are printed with fewer digits.
    assign unused_digits = ^{lat_deg_h, lat_min_h, lon_min_h};

    // Byte that follows the one currently held in tx_data_q.
    always_comb begin
        sel_idx   = idx_q + 5'd1;
        next_byte = 8'h00;
        case (sel_idx)
            5'd0:    next_byte = ASCII_DOLLAR;
            5'd1:    next_byte = TALKER_ID[15:8];
            5'd2:    next_byte = TALKER_ID[7:0];
            5'd3:    next_byte = ASCII_G;
            5'd4:    next_byte = ASCII_L;
            5'd5:    next_byte = ASCII_L;
            5'd6:    next_byte = ASCII_COMMA;
            5'd7:    next_byte = lat_deg_t;
            5'd8:    next_byte = lat_deg_o;
            5'd9:    next_byte = lat_min_t;
            5'd10:   next_byte = lat_min_o;
            5'd11:   next_byte = ASCII_COMMA;
            5'd12:   next_byte = lat_south_q ? ASCII_S : ASCII_N;
            5'd13:   next_byte = ASCII_COMMA;
            5'd14:   next_byte = lon_deg_h;
            5'd15:   next_byte = lon_deg_t;
            5'd16:   next_byte = lon_deg_o;
            5'd17:   next_byte = lon_min_t;
            5'd18:   next_byte = lon_min_o;
            5'd19:   next_byte = ASCII_COMMA;
            5'd20:   next_byte = lon_west_q ? ASCII_W : ASCII_E;
            5'd21:   next_byte = ASCII_COMMA;
            5'd22:   next_byte = valid_fix_q ? ASCII_A : ASCII_V;
`ifdef NMEA_CHECKSUM_EN
            5'd23:   next_byte = ASCII_STAR;
            5'd24:   next_byte = hex_ascii(csum_q[7:4]);
            5'd25:   next_byte = hex_ascii(csum_q[3:0]);
            5'd26:   next_byte = ASCII_CR;
            5'd27:   next_byte = ASCII_LF;
`else
            5'd23:   next_byte = ASCII_CR;
            5'd24:   next_byte = ASCII_LF;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    // Handshake: tx_start is raised only in SEND while tx_busy=0; the transmitter
    // acknowledges by raising tx_busy and signals completion by dropping it again.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        lat_deg_d   = lat_deg_q;
        lat_min_d   = lat_min_q;
        lon_deg_d   = lon_deg_q;
        lon_min_d   = lon_min_q;
        lat_south_d = lat_south_q;
        lon_west_d  = lon_west_q;
        valid_fix_d = valid_fix_q;
`ifdef NMEA_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LATCH;
                    busy_d      = 1'b1;
                    idx_d       = 5'd0;
                    lat_deg_d   = sat8(lat_deg, LAT_DEG_MAX);
                    lat_min_d   = sat8(lat_min, MIN_MAX);
                    lon_deg_d   = sat8(lon_deg, LON_DEG_MAX);
                    lon_min_d   = sat8(lon_min, MIN_MAX);
                    lat_south_d = lat_south;
                    lon_west_d  = lon_west;
                    valid_fix_d = valid_fix;
`ifdef NMEA_CHECKSUM_EN
                    csum_d      = 8'h00;
`endif
                end
            end
            LATCH: begin
                state_d   = SEND;
                idx_d     = 5'd0;
                tx_data_d = ASCII_DOLLAR;
            end
            SEND: begin
                if (!tx_busy) begin
                    state_d = WAIT_ACK;
`ifdef NMEA_CHECKSUM_EN
                    if (idx_q >= CSUM_FIRST_IDX && idx_q <= CSUM_LAST_IDX)
                        csum_d = csum_q ^ tx_data_q;
`endif
                end
            end
            WAIT_ACK: begin
                if (tx_busy)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = SEND;
                        idx_d     = idx_q + 5'd1;
                        tx_data_d = next_byte;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= 5'd0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lat_deg_q   <= 8'h00;
            lat_min_q   <= 8'h00;
            lon_deg_q   <= 8'h00;
            lon_min_q   <= 8'h00;
            lat_south_q <= 1'b0;
            lon_west_q  <= 1'b0;
            valid_fix_q <= 1'b0;
`ifdef NMEA_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lat_deg_q   <= lat_deg_d;
            lat_min_q   <= lat_min_d;
            lon_deg_q   <= lon_deg_d;
            lon_min_q   <= lon_min_d;
            lat_south_q <= lat_south_d;
            lon_west_q  <= lon_west_d;
            valid_fix_q <= valid_fix_d;
`ifdef NMEA_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // tx_start is decoded from state so the first '$' strobe lands two cycles after accept.
    assign tx_start  = (state_q == SEND) && !tx_busy;
    assign tx_data   = DATA_BITS'(tx_data_q);
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nmea_encoder.sv
// Table-driven bench for nmea_encoder with a byte scoreboard and a 10-cycle busy transmitter.
// Follows the NMEA_CHECKSUM_EN setting of the build.
module tb_nmea_encoder;
    import nmea_pkg::*;

`ifdef NMEA_CHECKSUM_EN
    localparam int SENT_LEN = SENTENCE_LEN_CSUM;
`else
    localparam int SENT_LEN = SENTENCE_LEN_NOCSUM;
`endif
    localparam int BUSY_LEN = 10;

    logic        clk_50MHz = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  lat_deg, lat_min, lon_deg, lon_min;
    logic        lat_south, lon_west, valid_fix;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy, done;
    nmea_state_e dbg_state;

    always #10 clk_50MHz = ~clk_50MHz;

    nmea_encoder dut (
        .clk_50MHz (clk_50MHz),
        .reset     (reset),
        .start     (start),
        .lat_deg   (lat_deg),
        .lat_min   (lat_min),
        .lon_deg   (lon_deg),
        .lon_min   (lon_min),
        .lat_south (lat_south),
        .lon_west  (lon_west),
        .valid_fix (valid_fix),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [7:0]  lat_deg, lat_min, lon_deg, lon_min;
        logic        lat_south, lon_west, valid_fix;
        logic [31:0] lat_s;
        logic [39:0] lon_s;
        logic [7:0]  ns, ew, st;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         first_tx_cyc = -1;
    int         tx_count = 0;
    int         done_cnt = 0;
    int         busy_cnt = 0;
    logic       pend = 1'b0;
    logic       hold_busy = 1'b0;
    logic       prev_start = 1'b0;

    always @(posedge clk_50MHz) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Transmitter model plus scoreboard: pops the expected byte on every tx_start.
    initial begin
        logic [7:0] exp_b;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk_50MHz);
            #1;
            if (pend) begin
                busy_cnt = BUSY_LEN;
                pend     = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt > 0) || hold_busy;
            @(negedge clk_50MHz);
            if (done) begin
                done_cnt++;
                check("busy_at_done", busy, 1);
            end
            if (tx_start) begin
                check("tx_start_while_busy", tx_busy, 0);
                check("tx_start_back_to_back", prev_start, 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_tx_start: got byte %0h, no byte expected", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check($sformatf("byte_%0d", tx_count), tx_data, exp_b);
                end
                if (first_tx_cyc < 0) first_tx_cyc = cyc;
                tx_count++;
                pend = 1'b1;
            end
            prev_start = tx_start;
        end
    end

    task automatic push_expected(input vec_t v);
        logic [7:0]  b[$];
        logic [7:0]  cs;
        logic [15:0] tk;
        string       hx;
        tk = 16'h4750;
        hx = "0123456789ABCDEF";
        b.push_back(8'h24);
        b.push_back(tk[15:8]);
        b.push_back(tk[7:0]);
        b.push_back("G");
        b.push_back("L");
        b.push_back("L");
        b.push_back(",");
        for (int i = 3; i >= 0; i--) b.push_back(v.lat_s[8*i +: 8]);
        b.push_back(",");
        b.push_back(v.ns);
        b.push_back(",");
        for (int i = 4; i >= 0; i--) b.push_back(v.lon_s[8*i +: 8]);
        b.push_back(",");
        b.push_back(v.ew);
        b.push_back(",");
        b.push_back(v.st);
        cs = 8'h00;
        for (int i = 1; i < b.size(); i++) cs ^= b[i];
`ifdef NMEA_CHECKSUM_EN
        b.push_back("*");
        b.push_back(hx[cs[7:4]]);
        b.push_back(hx[cs[3:0]]);
`endif
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) exp_q.push_back(b[i]);
    endtask

    task automatic apply_inputs(input vec_t v);
        lat_deg   = v.lat_deg;
        lat_min   = v.lat_min;
        lon_deg   = v.lon_deg;
        lon_min   = v.lon_min;
        lat_south = v.lat_south;
        lon_west  = v.lon_west;
        valid_fix = v.valid_fix;
    endtask

    task automatic drive_start(input vec_t v);
        @(posedge clk_50MHz);
        #1;
        apply_inputs(v);
        start        = 1'b1;
        start_cyc    = cyc;
        first_tx_cyc = -1;
        push_expected(v);
        @(posedge clk_50MHz);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 5000) begin
            @(negedge clk_50MHz);
            n++;
        end
        check(name, done_cnt, target);
    endtask

    task automatic wait_tx(input int target, input string name);
        int n = 0;
        while (tx_count < target && n < 5000) begin
            @(negedge clk_50MHz);
            n++;
        end
        check(name, tx_count, target);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_tx, base_done, n;
        vecs[0] = '{8'd4,   8'd36, 8'd74,  8'd5,  1'b0, 1'b1, 1'b1, "0436", "07405", "N", "W", "A"};
        vecs[1] = '{8'd4,   8'd36, 8'd74,  8'd5,  1'b0, 1'b1, 1'b0, "0436", "07405", "N", "W", "V"};
        vecs[2] = '{8'd200, 8'd75, 8'd255, 8'd99, 1'b1, 1'b0, 1'b1, "9059", "18059", "S", "E", "A"};
        vecs[3] = '{8'd90,  8'd59, 8'd180, 8'd59, 1'b0, 1'b0, 1'b1, "9059", "18059", "N", "E", "A"};
        vecs[4] = '{8'd0,   8'd0,  8'd0,   8'd0,  1'b1, 1'b1, 1'b0, "0000", "00000", "S", "W", "V"};
        vecs[5] = '{8'd91,  8'd60, 8'd181, 8'd60, 1'b0, 1'b1, 1'b1, "9059", "18059", "N", "W", "A"};
        vecs[6] = '{8'd9,   8'd9,  8'd99,  8'd9,  1'b1, 1'b0, 1'b0, "0909", "09909", "S", "E", "V"};
        vecs[7] = '{8'd89,  8'd58, 8'd179, 8'd58, 1'b0, 1'b0, 1'b1, "8958", "17958", "N", "E", "A"};

        reset = 1'b0;
        start = 1'b0;
        apply_inputs(vecs[0]);
        repeat (3) @(negedge clk_50MHz);
        check("reset_tx_start", tx_start, 0);
        check("reset_tx_data", tx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", dbg_state, IDLE);
        @(posedge clk_50MHz);
        #1;
        reset = 1'b1;

        // Main table: one full sentence per vector.
        for (int i = 0; i < 8; i++) begin
            base_tx   = tx_count;
            base_done = done_cnt;
            drive_start(vecs[i]);
            wait_done(base_done + 1, $sformatf("done_vec%0d", i));
            check($sformatf("latency_vec%0d", i), first_tx_cyc - start_cyc, 2);
            check($sformatf("bytes_vec%0d", i), tx_count - base_tx, SENT_LEN);
            check($sformatf("queue_empty_vec%0d", i), exp_q.size(), 0);
            @(negedge clk_50MHz);
            check($sformatf("idle_after_vec%0d", i), busy, 0);
        end

        // Restart while busy plus input changes after accept: only the first sentence goes out.
        base_tx   = tx_count;
        base_done = done_cnt;
        drive_start(vecs[0]);
        wait_tx(base_tx + 3, "midsent_progress");
        @(posedge clk_50MHz);
        #1;
        apply_inputs(vecs[2]);
        start = 1'b1;
        @(posedge clk_50MHz);
        #1;
        start = 1'b0;
        check("midsent_still_busy", busy, 1);
        wait_done(base_done + 1, "midsent_done");
        repeat (40) @(negedge clk_50MHz);
        check("midsent_bytes", tx_count - base_tx, SENT_LEN);
        check("midsent_single_done", done_cnt, base_done + 1);
        check("midsent_queue_empty", exp_q.size(), 0);

        // tx_busy held high across SEND: no strobe until it drops.
        hold_busy = 1'b1;
        @(posedge clk_50MHz);
        base_tx   = tx_count;
        base_done = done_cnt;
        drive_start(vecs[3]);
        repeat (500) @(negedge clk_50MHz);
        check("hold_no_tx_start", tx_count, base_tx);
        check("hold_state_send", dbg_state, SEND);
        hold_busy = 1'b0;
        n = 0;
        while (tx_count == base_tx && n < 5) begin
            @(negedge clk_50MHz);
            n++;
        end
        check("hold_release_tx_start", tx_count, base_tx + 1);
        wait_done(base_done + 1, "hold_done");

        // Start during the FINISH cycle is dropped.
        base_done = done_cnt;
        drive_start(vecs[1]);
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk_50MHz);
            n++;
        end
        check("finish_state", dbg_state, FINISH);
        start = 1'b1;
        @(posedge clk_50MHz);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk_50MHz);
        check("finish_start_ignored_state", dbg_state, IDLE);
        check("finish_start_ignored_busy", busy, 0);

        // Asynchronous reset after byte 10 aborts the sentence cleanly.
        base_tx   = tx_count;
        base_done = done_cnt;
        drive_start(vecs[6]);
        wait_tx(base_tx + 11, "abort_progress");
        @(negedge clk_50MHz);
        #3;
        reset = 1'b0;
        #1;
        check("abort_tx_start", tx_start, 0);
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, IDLE);
        exp_q.delete();
        base_tx = tx_count;
        repeat (5) @(negedge clk_50MHz);
        check("abort_no_done", done_cnt, base_done);
        check("abort_no_tx", tx_count, base_tx);
        @(posedge clk_50MHz);
        #1;
        reset = 1'b1;
        base_tx   = tx_count;
        base_done = done_cnt;
        drive_start(vecs[7]);
        wait_done(base_done + 1, "after_abort_done");
        check("after_abort_bytes", tx_count - base_tx, SENT_LEN);
        check("after_abort_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
